// File: rtl/tiny_rv_decode_pipe.sv
// rtl/tiny_rv_decode_pipe.sv - RV32I decode register stage with valid/ready handshake and optional skid buffer
//
// Parameters:
//   XLEN : width of pc and immediate (32 or 64); immediates sign-extend to XLEN
//   SKID : 1 = one-entry skid buffer, fetch_ready is a register
//          0 = no skid, fetch_ready = !decode_valid || decode_ready
// Ports:
//   i_clk, i_reset (asynchronous, active high), i_flush (synchronous)
//   fetch_valid / fetch_ready / fetch_pc / fetch_inst : upstream word
//   decode_valid / decode_ready                       : downstream handshake
//   decode_pc, decode_inst, decode_opcode, decode_funct3, decode_funct7,
//   decode_rs1, decode_rs2, decode_rd                 : raw fields of the accepted word
//   decode_imm                                        : sign-extended immediate
//   decode_fmt                                        : 0=R 1=I 2=S 3=B 4=U 5=J 6=ILL
//   decode_rs1_en, decode_rs2_en, decode_rd_en        : register-use flags
//   decode_illegal                                    : unsupported or non-32-bit encoding

module tiny_rv_decode_pipe #(
  parameter int XLEN = 32,
  parameter bit SKID = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_flush,
  input  logic            fetch_valid,
  output logic            fetch_ready,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic [31:0]     fetch_inst,
  output logic            decode_valid,
  input  logic            decode_ready,
  output logic [XLEN-1:0] decode_pc,
  output logic [31:0]     decode_inst,
  output logic [XLEN-1:0] decode_imm,
  output logic [6:0]      decode_opcode,
  output logic [2:0]      decode_funct3,
  output logic [6:0]      decode_funct7,
  output logic [4:0]      decode_rs1,
  output logic [4:0]      decode_rs2,
  output logic [4:0]      decode_rd,
  output logic [2:0]      decode_fmt,
  output logic            decode_rs1_en,
  output logic            decode_rs2_en,
  output logic            decode_rd_en,
  output logic            decode_illegal
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd6;

  // Everything the output stage needs from one decoded word; raw fields are
  // sliced back out of inst so they cannot disagree with it.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            rs1_en;
    logic            rs2_en;
    logic            rd_en;
    logic            illegal;
  } entry_t;

  entry_t      dec_entry;
  entry_t      out_q;
  entry_t      skid_q;
  logic        out_valid;
  logic        skid_valid;
  logic [2:0]  fmt;
  logic [31:0] imm32;
  logic        accept;
  logic        out_free;

  // Every supported opcode ends in 2'b11, so compressed / non-32-bit
  // encodings fall into the default branch and decode as illegal.
  always_comb begin
    fmt = FMT_ILL;
    case (fetch_inst[6:0])
      7'b0110111, 7'b0010111:                        fmt = FMT_U;
      7'b1101111:                                    fmt = FMT_J;
      7'b1100111, 7'b0000011, 7'b0010011,
      7'b0001111, 7'b1110011:                        fmt = FMT_I;
      7'b1100011:                                    fmt = FMT_B;
      7'b0100011:                                    fmt = FMT_S;
      7'b0110011:                                    fmt = FMT_R;
      default:                                       fmt = FMT_ILL;
    endcase
  end

  // 32-bit immediate; bit 31 is always inst[31], so widening to XLEN is a
  // plain sign extension of this value.
  always_comb begin
    imm32 = 32'd0;
    case (fmt)
      FMT_I: imm32 = {{20{fetch_inst[31]}}, fetch_inst[31:20]};
      FMT_S: imm32 = {{20{fetch_inst[31]}}, fetch_inst[31:25], fetch_inst[11:7]};
      FMT_B: imm32 = {{19{fetch_inst[31]}}, fetch_inst[31], fetch_inst[7],
                      fetch_inst[30:25], fetch_inst[11:8], 1'b0};
      FMT_U: imm32 = {fetch_inst[31:12], 12'd0};
      FMT_J: imm32 = {{11{fetch_inst[31]}}, fetch_inst[31], fetch_inst[19:12],
                      fetch_inst[20], fetch_inst[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  always_comb begin
    dec_entry         = '0;
    dec_entry.pc      = fetch_pc;
    dec_entry.inst    = fetch_inst;
    dec_entry.imm     = XLEN'($signed(imm32));
    dec_entry.fmt     = fmt;
    dec_entry.rs1_en  = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
    dec_entry.rs2_en  = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
    dec_entry.rd_en   = ((fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J))
                        && (fetch_inst[11:7] != 5'd0);
    dec_entry.illegal = (fmt == FMT_ILL);
  end

  // With SKID=1 fetch_ready is just the inverted skid flop, so it falls the
  // cycle after the skid fills and rises the cycle after it empties.
  assign fetch_ready = SKID ? ~skid_valid : (~out_valid | decode_ready);
  assign accept      = fetch_valid & fetch_ready;
  assign out_free    = ~out_valid | decode_ready;

  // The skid only ever loads while the output is stalled; with SKID=0 the
  // accept condition already implies out_free, so that branch never fires.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      out_valid  <= 1'b0;
      out_q      <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
    end else if (i_flush) begin
      out_valid  <= 1'b0;
      out_q      <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
    end else if (out_free) begin
      if (skid_valid) begin
        // fetch_ready is low while the skid is full, so no new word competes here.
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_q      <= dec_entry;
        out_valid  <= 1'b1;
      end else begin
        out_valid  <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= dec_entry;
      skid_valid <= 1'b1;
    end
  end

  assign decode_valid   = out_valid;
  assign decode_pc      = out_q.pc;
  assign decode_inst    = out_q.inst;
  assign decode_imm     = out_q.imm;
  assign decode_opcode  = out_q.inst[6:0];
  assign decode_funct3  = out_q.inst[14:12];
  assign decode_funct7  = out_q.inst[31:25];
  assign decode_rs1     = out_q.inst[19:15];
  assign decode_rs2     = out_q.inst[24:20];
  assign decode_rd      = out_q.inst[11:7];
  assign decode_fmt     = out_q.fmt;
  assign decode_rs1_en  = out_q.rs1_en;
  assign decode_rs2_en  = out_q.rs2_en;
  assign decode_rd_en   = out_q.rd_en;
  assign decode_illegal = out_q.illegal;

endmodule

// File: tb/tb_tiny_rv_decode_pipe.sv
// tb/tb_tiny_rv_decode_pipe.sv - directed bench for tiny_rv_decode_pipe (XLEN=32/SKID=1 and XLEN=64/SKID=0)

module tb_tiny_rv_decode_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Instance A: XLEN=32, SKID=1
  logic        a_rst, a_flush, a_fv, a_fr, a_dvalid, a_dr;
  logic [31:0] a_pc, a_inst, a_dpc, a_dinst, a_dimm;
  logic [6:0]  a_op, a_f7;
  logic [2:0]  a_f3, a_fmt;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic        a_rs1en, a_rs2en, a_rden, a_ill;

  tiny_rv_decode_pipe #(.XLEN(32), .SKID(1'b1)) dut_a (
    .i_clk(clk), .i_reset(a_rst), .i_flush(a_flush),
    .fetch_valid(a_fv), .fetch_ready(a_fr), .fetch_pc(a_pc), .fetch_inst(a_inst),
    .decode_valid(a_dvalid), .decode_ready(a_dr),
    .decode_pc(a_dpc), .decode_inst(a_dinst), .decode_imm(a_dimm),
    .decode_opcode(a_op), .decode_funct3(a_f3), .decode_funct7(a_f7),
    .decode_rs1(a_rs1), .decode_rs2(a_rs2), .decode_rd(a_rd),
    .decode_fmt(a_fmt), .decode_rs1_en(a_rs1en), .decode_rs2_en(a_rs2en),
    .decode_rd_en(a_rden), .decode_illegal(a_ill)
  );

  // Instance B: XLEN=64, SKID=0
  logic        b_rst, b_flush, b_fv, b_fr, b_dvalid, b_dr;
  logic [63:0] b_pc, b_dpc, b_dimm;
  logic [31:0] b_inst, b_dinst;
  logic [6:0]  b_op, b_f7;
  logic [2:0]  b_f3, b_fmt;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic        b_rs1en, b_rs2en, b_rden, b_ill;

  tiny_rv_decode_pipe #(.XLEN(64), .SKID(1'b0)) dut_b (
    .i_clk(clk), .i_reset(b_rst), .i_flush(b_flush),
    .fetch_valid(b_fv), .fetch_ready(b_fr), .fetch_pc(b_pc), .fetch_inst(b_inst),
    .decode_valid(b_dvalid), .decode_ready(b_dr),
    .decode_pc(b_dpc), .decode_inst(b_dinst), .decode_imm(b_dimm),
    .decode_opcode(b_op), .decode_funct3(b_f3), .decode_funct7(b_f7),
    .decode_rs1(b_rs1), .decode_rs2(b_rs2), .decode_rd(b_rd),
    .decode_fmt(b_fmt), .decode_rs1_en(b_rs1en), .decode_rs2_en(b_rs2en),
    .decode_rd_en(b_rden), .decode_illegal(b_ill)
  );

  // Output transfers of instance A, sampled on the falling edge.
  logic [31:0] mon_q[$];
  always @(negedge clk) begin
    if (!a_rst && a_dvalid && a_dr) mon_q.push_back(a_dinst);
  end

  // en = {rs1_en, rs2_en, rd_en, illegal}
  typedef struct {
    logic [31:0] inst;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [3:0]  en;
    logic [4:0]  rd;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  localparam logic [31:0] I_ADDI = 32'hFFF00293;
  localparam logic [31:0] I_SW   = 32'h0021A223;
  localparam logic [31:0] I_BEQ  = 32'hFE000EE3;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LUI  = 32'h800000B7;
  localparam logic [31:0] I_JALN = 32'h801FF06F;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{32'h008000EF, 3'd5, 32'h00000008, 4'b0010, 5'd1};
    vecs[1]  = '{32'hFFF00293, 3'd1, 32'hFFFFFFFF, 4'b1010, 5'd5};
    vecs[2]  = '{32'h0021A223, 3'd2, 32'h00000004, 4'b1100, 5'd4};
    vecs[3]  = '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 4'b1100, 5'd29};
    vecs[4]  = '{32'h00000000, 3'd6, 32'h00000000, 4'b0001, 5'd0};
    vecs[5]  = '{32'h0000007F, 3'd6, 32'h00000000, 4'b0001, 5'd0};
    vecs[6]  = '{32'h800000B7, 3'd4, 32'h80000000, 4'b0010, 5'd1};
    vecs[7]  = '{32'h002081B3, 3'd0, 32'h00000000, 4'b1110, 5'd3};
    vecs[8]  = '{32'h00000013, 3'd1, 32'h00000000, 4'b1000, 5'd0};
    vecs[9]  = '{32'h00000001, 3'd6, 32'h00000000, 4'b0001, 5'd0};
    vecs[10] = '{32'h12345117, 3'd4, 32'h12345000, 4'b0010, 5'd2};
    vecs[11] = '{32'hFF83A303, 3'd1, 32'hFFFFFFF8, 4'b1010, 5'd6};
    vecs[12] = '{32'h000280E7, 3'd1, 32'h00000000, 4'b1010, 5'd1};
    vecs[13] = '{32'h0000000B, 3'd6, 32'h00000000, 4'b0001, 5'd0};
    vecs[14] = '{32'h801FF06F, 3'd5, 32'hFFFFF800, 4'b0000, 5'd0};
    vecs[15] = '{32'hFE530FA3, 3'd2, 32'hFFFFFFFF, 4'b1100, 5'd31};

    a_rst = 1'b1; a_flush = 1'b0; a_fv = 1'b0; a_dr = 1'b0; a_pc = '0; a_inst = '0;
    b_rst = 1'b1; b_flush = 1'b0; b_fv = 1'b0; b_dr = 1'b0; b_pc = '0; b_inst = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("a reset valid",  64'(a_dvalid), 64'(0));
    chk("a reset ready",  64'(a_fr),     64'(1));
    chk("a reset data",   64'({a_dpc, a_dinst}), 64'(0));
    chk("a reset dec",    64'({a_dimm, a_fmt, a_rs1en, a_rs2en, a_rden, a_ill}), 64'(0));
    chk("b reset valid",  64'(b_dvalid), 64'(0));
    chk("b reset ready",  64'(b_fr),     64'(1));
    a_rst = 1'b0;
    b_rst = 1'b0;

    // Back-to-back table, decode_ready high: one word per cycle, 1-cycle latency.
    a_dr = 1'b1;
    a_fv = 1'b1;
    for (int i = 0; i < NV; i++) begin
      a_inst = vecs[i].inst;
      a_pc   = 32'h100 + 32'(i * 4);
      chk($sformatf("v%0d fetch_ready", i), 64'(a_fr), 64'(1));
      tick();
      chk($sformatf("v%0d valid", i), 64'(a_dvalid), 64'(1));
      chk($sformatf("v%0d fmt", i),   64'(a_fmt),    64'(vecs[i].fmt));
      chk($sformatf("v%0d imm", i),   64'(a_dimm),   64'(vecs[i].imm));
      chk($sformatf("v%0d en", i),    64'({a_rs1en, a_rs2en, a_rden, a_ill}), 64'(vecs[i].en));
      chk($sformatf("v%0d rd", i),    64'(a_rd),     64'(vecs[i].rd));
      chk($sformatf("v%0d pc", i),    64'(a_dpc),    64'(32'h100 + 32'(i * 4)));
      chk($sformatf("v%0d raw", i),   64'({a_f7, a_rs2, a_rs1, a_f3, a_rd, a_op}), 64'(vecs[i].inst));
      chk($sformatf("v%0d inst", i),  64'(a_dinst),  64'(vecs[i].inst));
    end
    a_fv = 1'b0;
    tick();
    chk("drain empty", 64'(a_dvalid), 64'(0));

    // Skid: A at output, B in skid, C refused while stalled.
    mon_q.delete();
    a_dr = 1'b0; a_fv = 1'b1; a_inst = I_ADDI; a_pc = 32'h200;
    tick();
    chk("skid A out",    64'(a_dinst), 64'(I_ADDI));
    chk("skid A ready",  64'(a_fr),    64'(1));
    a_inst = I_SW; a_pc = 32'h204;
    tick();
    chk("skid B held A", 64'(a_dinst), 64'(I_ADDI));
    chk("skid full rdy", 64'(a_fr),    64'(0));
    a_inst = I_BEQ; a_pc = 32'h208;
    tick();
    chk("skid C held A", 64'(a_dinst), 64'(I_ADDI));
    chk("skid C imm",    64'(a_dimm),  64'(32'hFFFFFFFF));
    chk("skid C rdy",    64'(a_fr),    64'(0));
    a_dr = 1'b1;
    tick();
    chk("rel B out",     64'(a_dinst), 64'(I_SW));
    chk("rel B pc",      64'(a_dpc),   64'(32'h204));
    chk("rel rdy back",  64'(a_fr),    64'(1));
    tick();
    chk("rel C out",     64'(a_dinst), 64'(I_BEQ));
    a_fv = 1'b0;
    tick();
    chk("rel empty",     64'(a_dvalid), 64'(0));
    chk("order count",   64'(mon_q.size()), 64'(3));
    if (mon_q.size() == 3) begin
      chk("order 0", 64'(mon_q[0]), 64'(I_ADDI));
      chk("order 1", 64'(mon_q[1]), 64'(I_SW));
      chk("order 2", 64'(mon_q[2]), 64'(I_BEQ));
    end

    // Flush with output and skid full and a word presented.
    a_dr = 1'b0; a_fv = 1'b1; a_inst = I_JAL; a_pc = 32'h300;
    tick();
    a_inst = I_ADD; a_pc = 32'h304;
    tick();
    chk("flush pre rdy", 64'(a_fr), 64'(0));
    a_flush = 1'b1; a_inst = I_LUI; a_pc = 32'h308;
    tick();
    a_flush = 1'b0; a_fv = 1'b0;
    chk("flush valid",   64'(a_dvalid), 64'(0));
    chk("flush ready",   64'(a_fr),     64'(1));
    chk("flush data",    64'({a_dpc, a_dinst}), 64'(0));
    chk("flush dec",     64'({a_dimm, a_fmt, a_rs1en, a_rs2en, a_rden, a_ill}), 64'(0));
    mon_q.delete();
    a_dr = 1'b1;
    repeat (3) tick();
    chk("flush no leak", 64'(mon_q.size()), 64'(0));

    // Flush on an empty stage discards the word presented that cycle.
    a_fv = 1'b1; a_flush = 1'b1; a_inst = I_ADDI; a_pc = 32'h400;
    tick();
    a_flush = 1'b0; a_fv = 1'b0;
    chk("flush drop", 64'(a_dvalid), 64'(0));
    tick();
    chk("flush drop2", 64'(a_dvalid), 64'(0));

    // XLEN=64, SKID=0.
    b_dr = 1'b0; b_fv = 1'b1; b_inst = I_LUI; b_pc = 64'h0000_0001_0000_0000;
    tick();
    chk("b lui valid", 64'(b_dvalid), 64'(1));
    chk("b lui imm",   b_dimm,        64'hFFFF_FFFF_8000_0000);
    chk("b lui fmt",   64'(b_fmt),    64'(4));
    chk("b lui en",    64'({b_rs1en, b_rs2en, b_rden, b_ill}), 64'(4'b0010));
    chk("b lui raw",   64'({b_f7, b_rs2, b_rs1, b_f3, b_rd, b_op}), 64'(I_LUI));
    chk("b lui pc",    b_dpc,         64'h0000_0001_0000_0000);
    chk("b stall rdy", 64'(b_fr),     64'(0));
    b_dr = 1'b1;
    #1;
    chk("b comb rdy",  64'(b_fr),     64'(1));
    b_inst = I_JALN; b_pc = 64'h0000_0001_0000_0004;
    tick();
    chk("b jal imm",   b_dimm,        64'hFFFF_FFFF_FFFF_F800);
    chk("b jal inst",  64'(b_dinst),  64'(I_JALN));
    b_inst = I_ADDI; b_pc = 64'h0000_0001_0000_0008;
    @(posedge clk);
    #3;
    b_rst = 1'b1;
    #1;
    chk("b async valid", 64'(b_dvalid), 64'(0));
    chk("b async data",  64'(b_dinst),  64'(0));
    chk("b async imm",   b_dimm,        64'(0));
    chk("b async pc",    b_dpc,         64'(0));
    chk("b async dec",   64'({b_fmt, b_rs1en, b_rs2en, b_rden, b_ill}), 64'(0));
    @(posedge clk);
    #1;
    b_rst = 1'b0;
    tick();
    chk("b post valid", 64'(b_dvalid), 64'(1));
    chk("b post imm",   b_dimm,        64'hFFFF_FFFF_FFFF_FFFF);
    b_fv = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
